// File: rtl/universal_register_pkg.sv
// Shared definitions for the universal register: mode field type and mode codes.
package universal_register_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'd0;
    localparam mode_t MODE_LOAD = 3'd1;
    localparam mode_t MODE_SHL  = 3'd2;
    localparam mode_t MODE_SHR  = 3'd3;
    localparam mode_t MODE_ROL  = 3'd4;
    localparam mode_t MODE_ROR  = 3'd5;
    localparam mode_t MODE_INC  = 3'd6;
    localparam mode_t MODE_DEC  = 3'd7;

endpackage

// File: rtl/universal_register.sv
// WIDTH-bit universal register: load, shift, rotate, up/down count with optional
// saturation, serial I/O and a combinational terminal-count flag.
module universal_register
    import universal_register_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             CLR,
    input  logic             EN,
    input  mode_t            M,
    input  logic [WIDTH-1:0] D,
    input  logic             SIL,
    input  logic             SIR,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             TC
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d;
    logic             q_at_max, q_at_min;

    assign q_at_max = (q_q == ALL_ONES);
    assign q_at_min = (q_q == '0);

    always_comb begin
        q_d  = q_q;
        so_d = so_q;
        if (CLR) begin
            q_d  = '0;
            so_d = 1'b0;
        end else if (EN) begin
            case (M)
                MODE_HOLD: ;
                MODE_LOAD: q_d = D;
                MODE_SHL: begin
                    q_d  = {q_q[WIDTH-2:0], SIL};
                    so_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d  = {SIR, q_q[WIDTH-1:1]};
                    so_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    so_d = q_q[WIDTH-1];
                end
                MODE_ROR: begin
                    q_d  = {q_q[0], q_q[WIDTH-1:1]};
                    so_d = q_q[0];
                end
                // Saturating counters park at the limit; wrapping ones roll over.
                MODE_INC: begin
                    if (!(SATURATE && q_at_max)) q_d = q_q + ONE;
                end
                MODE_DEC: begin
                    if (!(SATURATE && q_at_min)) q_d = q_q - ONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            q_q  <= RESET_VAL;
            so_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            so_q <= so_d;
        end
    end

    assign Q  = q_q;
    assign SO = so_q;
    // R gates TC so a zero RESET_VAL cannot flag a terminal count during reset.
    assign TC = ~R & EN & ~CLR &
                (((M == MODE_INC) & q_at_max) | ((M == MODE_DEC) & q_at_min));

endmodule

// File: tb/tb_universal_register.sv
// Bench for universal_register: three instances (wrap, saturate, RESET_VAL=5)
// driven in lockstep and checked against an arithmetic reference model.
module tb_universal_register;

    localparam int N = 3;

    logic       clk;
    logic       r;
    logic       clr;
    logic       en;
    logic [2:0] m;
    logic [3:0] d;
    logic       sil;
    logic       sir;
    logic [3:0] q_o  [N];
    logic       so_o [N];
    logic       tc_o [N];

    int sat_p [N] = '{0, 1, 0};
    int rv_p  [N] = '{0, 0, 5};

    int mq  [N];
    int mso [N];

    logic [4:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    universal_register #(.WIDTH(4), .RESET_VAL(4'h0), .SATURATE(1'b0)) u_wrap (
        .CLK(clk), .R(r), .CLR(clr), .EN(en), .M(m), .D(d), .SIL(sil), .SIR(sir),
        .Q(q_o[0]), .SO(so_o[0]), .TC(tc_o[0])
    );
    universal_register #(.WIDTH(4), .RESET_VAL(4'h0), .SATURATE(1'b1)) u_sat (
        .CLK(clk), .R(r), .CLR(clr), .EN(en), .M(m), .D(d), .SIL(sil), .SIR(sir),
        .Q(q_o[1]), .SO(so_o[1]), .TC(tc_o[1])
    );
    universal_register #(.WIDTH(4), .RESET_VAL(4'h5), .SATURATE(1'b0)) u_rv (
        .CLK(clk), .R(r), .CLR(clr), .EN(en), .M(m), .D(d), .SIL(sil), .SIR(sir),
        .Q(q_o[2]), .SO(so_o[2]), .TC(tc_o[2])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: plain arithmetic on integers, mode 0..7 as documented
    function automatic logic [4:0] model_next(int i);
        int qv = mq[i];
        int nq = mq[i];
        int ns = mso[i];
        if (clr) begin
            nq = 0;
            ns = 0;
        end else if (en) begin
            case (m)
                3'd1: nq = int'(d);
                3'd2: begin ns = qv / 8; nq = (qv * 2) % 16 + int'(sil); end
                3'd3: begin ns = qv % 2; nq = qv / 2 + int'(sir) * 8; end
                3'd4: begin ns = qv / 8; nq = (qv * 2) % 16 + qv / 8; end
                3'd5: begin ns = qv % 2; nq = qv / 2 + (qv % 2) * 8; end
                3'd6: nq = (sat_p[i] == 1 && qv == 15) ? 15 : (qv + 1) % 16;
                3'd7: nq = (sat_p[i] == 1 && qv == 0) ? 0 : (qv + 15) % 16;
                default: ;
            endcase
        end
        return 5'(ns * 16 + nq);
    endfunction

    function automatic logic model_tc(int i);
        if (r || !en || clr) return 1'b0;
        return (m == 3'd6 && mq[i] == 15) || (m == 3'd7 && mq[i] == 0);
    endfunction

    // driver: called at posedge+1, applies one operation across one clock edge
    task automatic apply(input logic clr_v, input logic en_v, input logic [2:0] m_v,
                         input logic [3:0] d_v, input logic sil_v, input logic sir_v);
        logic [4:0] e;
        clr = clr_v; en = en_v; m = m_v; d = d_v; sil = sil_v; sir = sir_v;
        #2;
        for (int i = 0; i < N; i++) begin
            check($sformatf("tc[%0d] m=%0d", i, m_v), 32'(tc_o[i]), 32'(model_tc(i)));
            exp_q.push_back(model_next(i));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            e = exp_q.pop_front();
            check($sformatf("q[%0d] m=%0d", i, m_v), 32'(q_o[i]), 32'(e[3:0]));
            check($sformatf("so[%0d] m=%0d", i, m_v), 32'(so_o[i]), 32'(e[4]));
            mq[i]  = int'(e[3:0]);
            mso[i] = int'(e[4]);
        end
    endtask

    task automatic op(input logic [2:0] m_v, input logic [3:0] d_v = 4'h0,
                      input logic sil_v = 1'b0, input logic sir_v = 1'b0);
        apply(1'b0, 1'b1, m_v, d_v, sil_v, sir_v);
    endtask

    // asynchronous reset pulse between edges, held across one edge
    task automatic async_reset();
        clr = 1'b0; en = 1'b1; m = 3'd7;
        #3;
        r = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_q[%0d]", i), 32'(q_o[i]), 32'(rv_p[i]));
            check($sformatf("rst_so[%0d]", i), 32'(so_o[i]), 32'd0);
            check($sformatf("rst_tc[%0d]", i), 32'(tc_o[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_hold_q[%0d]", i), 32'(q_o[i]), 32'(rv_p[i]));
            mq[i]  = rv_p[i];
            mso[i] = 0;
        end
        r = 1'b0;
    endtask

    initial begin
        r = 1'b1; clr = 1'b0; en = 1'b0; m = 3'd0; d = 4'h0; sil = 1'b0; sir = 1'b0;
        for (int i = 0; i < N; i++) begin
            mq[i]  = rv_p[i];
            mso[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        r = 1'b0;
        for (int i = 0; i < N; i++)
            check($sformatf("init_q[%0d]", i), 32'(q_o[i]), 32'(rv_p[i]));

        // async reset after a load
        op(3'd1, 4'hA);
        check("load_a", 32'(q_o[2]), 32'hA);
        async_reset();
        check("rv_after_reset", 32'(q_o[2]), 32'h5);

        // shifts
        op(3'd1, 4'hB);
        op(3'd2, 4'h0, 1'b1, 1'b0);
        check("shl_q", 32'(q_o[0]), 32'h7);
        check("shl_so", 32'(so_o[0]), 32'h1);
        op(3'd3, 4'h0, 1'b1, 1'b0);
        check("shr0_q", 32'(q_o[0]), 32'h3);
        op(3'd3, 4'h0, 1'b0, 1'b1);
        check("shr1_q", 32'(q_o[0]), 32'h9);
        check("shr1_so", 32'(so_o[0]), 32'h1);

        // rotates
        op(3'd1, 4'h9);
        op(3'd4, 4'h0, 1'b0, 1'b0);
        check("rol_q", 32'(q_o[0]), 32'h3);
        op(3'd5, 4'h0, 1'b1, 1'b1);
        check("ror_q", 32'(q_o[0]), 32'h9);
        repeat (4) op(3'd4, 4'h0, 1'b1, 1'b1);
        check("rol4_q", 32'(q_o[0]), 32'h9);

        // count up through the limit
        op(3'd1, 4'hE);
        op(3'd6);
        check("inc_f", 32'(q_o[0]), 32'hF);
        repeat (3) op(3'd6);
        check("inc_wrap", 32'(q_o[0]), 32'h2);
        check("inc_sat", 32'(q_o[1]), 32'hF);

        // count down through the limit
        op(3'd1, 4'h1);
        op(3'd7);
        check("dec_0", 32'(q_o[0]), 32'h0);
        op(3'd7);
        check("dec_wrap", 32'(q_o[0]), 32'hF);
        check("dec_sat", 32'(q_o[1]), 32'h0);

        // priority: clear beats enable/load, disabled count holds with TC low
        op(3'd1, 4'h6);
        apply(1'b1, 1'b1, 3'd1, 4'hF, 1'b1, 1'b1);
        check("clr_q", 32'(q_o[0]), 32'h0);
        op(3'd1, 4'hF);
        apply(1'b0, 1'b0, 3'd6, 4'h3, 1'b1, 1'b1);
        check("en0_hold", 32'(q_o[0]), 32'hF);

        // randomized operation mix
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset();
            end else begin
                apply(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) != 0),
                      3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
